// File: rtl/snn_stream_seq.sv
`default_nettype none
// ============================================================================
// snn_stream_seq : job-stream sequencer (line buffer, ker/wgt load, conv issue)
// Rev 1.0
// ============================================================================
module snn_stream_seq #(
  parameter int IMG_W     = 6,
  parameter int IMG_H     = 6,
  parameter int N_FRAMES  = 2,
  parameter int KER_LEN   = 9,
  parameter int W_LEN     = 4,
  parameter int DRAIN_CYC = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid_i,
  output logic       busy_o,
  output logic       pix_we_o,
  output logic [2:0] pix_col_o,
  output logic [1:0] pix_lb_row_o,
  output logic       ker_we_o,
  output logic [3:0] ker_idx_o,
  output logic       wgt_we_o,
  output logic [1:0] wgt_idx_o,
  output logic       conv_valid_o,
  output logic [1:0] conv_rot_o,
  output logic [2:0] win_row_o,
  output logic [2:0] win_col_o,
  output logic       frame_id_o,
  output logic       frame_last_win_o,
  output logic       job_done_o,
  output logic       abort_o,
  output logic       proto_err_o
);

  localparam logic [6:0] C_IMG_W     = 7'(IMG_W);
  localparam logic [6:0] C_FRAME_LEN = 7'(IMG_W * IMG_H);
  localparam logic [6:0] C_LAST_BEAT = 7'(N_FRAMES * IMG_W * IMG_H - 1);
  localparam logic [6:0] C_KER_LEN   = 7'(KER_LEN);
  localparam logic [6:0] C_W_LEN     = 7'(W_LEN);
  localparam logic [2:0] C_LAST_ROW  = 3'(IMG_H - 1);
  localparam logic [2:0] C_LAST_COL  = 3'(IMG_W - 1);
  localparam int         DW          = $clog2(DRAIN_CYC);
  localparam logic [DW-1:0] C_DRAIN_LAST = DW'(DRAIN_CYC - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RECV  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          job_done_q, job_done_d;
  logic          abort_q, abort_d;
  logic          proto_err_q, proto_err_d;

  logic       accept;
  logic       in_frame1;
  logic [6:0] pos;
  logic [2:0] row;
  logic [2:0] col;
  logic [1:0] lb_row;
  logic       win_ok;

  // Beat decode; cnt_q is 0 in IDLE so beat 0 decodes in the start cycle.
  assign accept    = in_valid_i && rst_n && (state_q != S_DRAIN);
  assign in_frame1 = (cnt_q >= C_FRAME_LEN);
  assign pos       = in_frame1 ? (cnt_q - C_FRAME_LEN) : cnt_q;
  assign row       = 3'(pos / C_IMG_W);
  assign col       = 3'(pos % C_IMG_W);
  assign lb_row    = (row >= 3'd3) ? 2'(row - 3'd3) : row[1:0];
  assign win_ok    = accept && (row >= 3'd2) && (col >= 3'd2);

  assign busy_o           = (state_q != S_IDLE);
  assign pix_we_o         = accept;
  assign pix_col_o        = accept ? col : 3'd0;
  assign pix_lb_row_o     = accept ? lb_row : 2'd0;
  assign frame_id_o       = accept && in_frame1;
  assign ker_we_o         = accept && (cnt_q < C_KER_LEN);
  assign ker_idx_o        = ker_we_o ? cnt_q[3:0] : 4'd0;
  assign wgt_we_o         = accept && (cnt_q < C_W_LEN);
  assign wgt_idx_o        = wgt_we_o ? cnt_q[1:0] : 2'd0;
  // Current beat is the bottom-right tap, so the oldest row sits one past it.
  assign conv_valid_o     = win_ok;
  assign conv_rot_o       = !win_ok ? 2'd0 : (lb_row == 2'd2) ? 2'd0 : (lb_row + 2'd1);
  assign win_row_o        = win_ok ? (row - 3'd2) : 3'd0;
  assign win_col_o        = win_ok ? (col - 3'd2) : 3'd0;
  assign frame_last_win_o = win_ok && (row == C_LAST_ROW) && (col == C_LAST_COL);
  assign job_done_o       = job_done_q;
  assign abort_o          = abort_q;
  assign proto_err_o      = proto_err_q;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    drain_d     = drain_q;
    job_done_d  = 1'b0;
    abort_d     = 1'b0;
    proto_err_d = proto_err_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          proto_err_d = 1'b0;
          state_d     = S_RECV;
          cnt_d       = 7'd1;
        end
      end
      S_RECV: begin
        if (!in_valid_i) begin
          abort_d = 1'b1;
          state_d = S_IDLE;
          cnt_d   = 7'd0;
        end else if (cnt_q == C_LAST_BEAT) begin
          // The last-beat cycle counts as drain cycle 0.
          state_d = S_DRAIN;
          cnt_d   = 7'd0;
          drain_d = DW'(1);
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      S_DRAIN: begin
        if (in_valid_i) proto_err_d = 1'b1;
        if (drain_q == C_DRAIN_LAST) begin
          state_d    = S_IDLE;
          drain_d    = '0;
          job_done_d = 1'b1;
        end else begin
          drain_d = drain_q + DW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= 7'd0;
      drain_q     <= '0;
      job_done_q  <= 1'b0;
      abort_q     <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      drain_q     <= drain_d;
      job_done_q  <= job_done_d;
      abort_q     <= abort_d;
      proto_err_q <= proto_err_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_snn_stream_seq.sv
`default_nettype none
// ============================================================================
// tb_snn_stream_seq : directed bench for snn_stream_seq
// Rev 1.0
// ============================================================================
module tb_snn_stream_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid_i;
  logic       busy_o, pix_we_o, ker_we_o, wgt_we_o, conv_valid_o;
  logic       frame_id_o, frame_last_win_o, job_done_o, abort_o, proto_err_o;
  logic [2:0] pix_col_o, win_row_o, win_col_o;
  logic [1:0] pix_lb_row_o, wgt_idx_o, conv_rot_o;
  logic [3:0] ker_idx_o;

  int n_vec = 0;
  int n_err = 0;
  int n_conv_obs = 0;
  int n_last_obs = 0;

  always #5 clk = ~clk;

  snn_stream_seq dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid_i       (in_valid_i),
    .busy_o           (busy_o),
    .pix_we_o         (pix_we_o),
    .pix_col_o        (pix_col_o),
    .pix_lb_row_o     (pix_lb_row_o),
    .ker_we_o         (ker_we_o),
    .ker_idx_o        (ker_idx_o),
    .wgt_we_o         (wgt_we_o),
    .wgt_idx_o        (wgt_idx_o),
    .conv_valid_o     (conv_valid_o),
    .conv_rot_o       (conv_rot_o),
    .win_row_o        (win_row_o),
    .win_col_o        (win_col_o),
    .frame_id_o       (frame_id_o),
    .frame_last_win_o (frame_last_win_o),
    .job_done_o       (job_done_o),
    .abort_o          (abort_o),
    .proto_err_o      (proto_err_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " strobes"},
        {pix_we_o, pix_col_o, pix_lb_row_o, ker_we_o, ker_idx_o, wgt_we_o, wgt_idx_o,
         conv_valid_o, conv_rot_o, win_row_o, win_col_o, frame_id_o, frame_last_win_o},
        32'd0);
  endtask

  // One accepted beat: expected decode derived from the beat index.
  task automatic beat(input int b, input bit busy_exp);
    int p, r, c;
    bit cv;
    @(negedge clk);
    in_valid_i = 1'b1;
    #1;
    p  = b % 36;
    r  = p / 6;
    c  = p % 6;
    cv = (r >= 2) && (c >= 2);
    chk($sformatf("b%0d pix", b), {pix_we_o, pix_col_o, pix_lb_row_o, frame_id_o},
        {1'b1, 3'(c), 2'(r % 3), 1'(b / 36)});
    chk($sformatf("b%0d ker", b), {ker_we_o, ker_idx_o}, (b < 9) ? {1'b1, 4'(b)} : 5'd0);
    chk($sformatf("b%0d wgt", b), {wgt_we_o, wgt_idx_o}, (b < 4) ? {1'b1, 2'(b)} : 3'd0);
    chk($sformatf("b%0d win", b),
        {conv_valid_o, conv_rot_o, win_row_o, win_col_o, frame_last_win_o},
        cv ? {1'b1, 2'((r + 1) % 3), 3'(r - 2), 3'(c - 2), 1'(r == 5 && c == 5)} : 10'd0);
    chk($sformatf("b%0d busy", b), busy_o, busy_exp);
    n_conv_obs += int'(conv_valid_o);
    n_last_obs += int'(frame_last_win_o);
    // Hand-computed spot vectors.
    case (b)
      14: chk("b14 first win", {conv_valid_o, conv_rot_o, win_row_o, win_col_o}, {1'b1, 2'd0, 3'd0, 3'd0});
      20: chk("b20 rot", {pix_lb_row_o, conv_rot_o, win_row_o, win_col_o}, {2'd0, 2'd1, 3'd1, 3'd0});
      26: chk("b26 rot", {pix_lb_row_o, conv_rot_o, win_row_o}, {2'd1, 2'd2, 3'd2});
      35: chk("b35 last", {frame_last_win_o, win_row_o, win_col_o, conv_rot_o}, {1'b1, 3'd3, 3'd3, 2'd0});
      38: chk("b38 frame1", {pix_lb_row_o, frame_id_o, conv_valid_o, pix_col_o}, {2'd0, 1'b1, 1'b0, 3'd2});
      71: chk("b71 last", {frame_last_win_o, frame_id_o, win_row_o, win_col_o}, {1'b1, 1'b1, 3'd3, 3'd3});
      default: ;
    endcase
  endtask

  task automatic run_beats(input int first, input int last);
    if (first == 0) begin
      n_conv_obs = 0;
      n_last_obs = 0;
    end
    for (int b = first; b <= last; b++) beat(b, b != 0);
  endtask

  task automatic chk_job_counts(input string tag);
    chk({tag, " conv count"}, n_conv_obs, 32);
    chk({tag, " last_win count"}, n_last_obs, 2);
  endtask

  // Cycles after beat 71; optional in_valid violation on drain cycles 1-2,
  // optional back-to-back start in the job_done cycle.
  task automatic drain(input string tag, input bit viol, input bit next);
    for (int d = 1; d <= 4; d++) begin
      if (d == 4 && next) begin
        beat(0, 1'b0);
        chk({tag, " b2b done"}, job_done_o, 1'b1);
        chk({tag, " b2b perr"}, proto_err_o, viol);
      end else begin
        @(negedge clk);
        in_valid_i = viol && (d <= 2);
        #1;
        chk_quiet($sformatf("%s d%0d", tag, d));
        chk($sformatf("%s d%0d busy", tag, d), busy_o, d < 4);
        chk($sformatf("%s d%0d done", tag, d), job_done_o, d == 4);
        if (viol) chk($sformatf("%s d%0d perr", tag, d), proto_err_o, d >= 2);
      end
    end
    if (!next) begin
      @(negedge clk);
      in_valid_i = 1'b0;
      #1;
      chk({tag, " done pulse end"}, {job_done_o, busy_o}, 2'b00);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    in_valid_i = 1'b0;
    #3;
    chk_quiet("reset");
    chk("reset flags", {busy_o, job_done_o, abort_o, proto_err_o}, 4'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("idle flags", {busy_o, job_done_o, abort_o, proto_err_o}, 4'd0);

    // Job A: full job, drain violation, next job starts in the job_done cycle.
    run_beats(0, 71);
    chk_job_counts("jobA");
    drain("jobA", 1'b1, 1'b1);

    // Job B: beat 0 already issued; proto_err clears, then abort after beat 19.
    run_beats(1, 1);
    chk("jobB perr cleared", proto_err_o, 1'b0);
    run_beats(2, 19);
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    chk_quiet("drop");
    chk("drop flags", {busy_o, abort_o, job_done_o}, 3'b100);
    @(negedge clk);
    #1;
    chk("abort pulse", {busy_o, abort_o, job_done_o}, 3'b010);
    @(negedge clk);
    #1;
    chk("abort end", {busy_o, abort_o, job_done_o}, 3'b000);

    // Job C: clean full job after the abort.
    run_beats(0, 71);
    chk_job_counts("jobC");
    drain("jobC", 1'b0, 1'b0);

    // Job D: async reset while beat 40 is on the bus.
    run_beats(0, 40);
    #2;
    rst_n = 1'b0;
    #1;
    chk_quiet("midreset");
    chk("midreset flags", {busy_o, job_done_o, abort_o, proto_err_o}, 4'd0);
    @(negedge clk);
    in_valid_i = 1'b0;
    #1;
    rst_n = 1'b1;

    // Job E: restarts cleanly from beat 0.
    run_beats(0, 71);
    chk_job_counts("jobE");
    drain("jobE", 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
